// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter and fetch-control stage of the single-cycle CPU. Holds the
// PC, presents it to InstructMemory, watches the returned word for HALT,
// chooses the next PC and stops fetch on an illegal redirect target. A
// saturating count of PC advances is kept for the test benches.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   Stall         in   hold PC this cycle
//   Branch        in   taken conditional branch
//   BranchOffset  in   [31:0] sign-extended word offset
//   Jump          in   J-type jump
//   JumpIndex     in   [25:0] J-type target field
//   JumpReg       in   jump to register value
//   RegTarget     in   [31:0] register jump target
//   Instruct      in   [31:0] word fetched from ImemRdAddr
//   ImemRdAddr    out  [31:0] current PC (byte address)
//   PCPlus4       out  [31:0] sequential successor, wrapped to memory size
//   Halted        out  fetch stopped by HALT
//   AddrFault     out  fetch stopped by illegal redirect target
//   FetchCount    out  [31:0] PC advances since reset
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES  = 256,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Branch,
  input  logic [31:0] BranchOffset,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  input  logic        JumpReg,
  input  logic [31:0] RegTarget,
  input  logic [31:0] Instruct,
  output logic [31:0] ImemRdAddr,
  output logic [31:0] PCPlus4,
  output logic        Halted,
  output logic        AddrFault,
  output logic [31:0] FetchCount
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);
  localparam logic [31:0] ADDR_MASK  = IMEM_LIMIT - 32'd1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT,
    ST_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;

  logic [31:0] pc_plus4_raw;
  logic [31:0] pc_plus4_wrap;
  logic [31:0] next_pc;
  logic        redirect;
  logic        target_bad;

  // Only the opcode field matters here; the rest of the word is decoded
  // downstream.
  logic        unused_instruct_bits;
  assign unused_instruct_bits = ^Instruct[25:0];

  // Jump and Branch are relative to the unwrapped successor; only the
  // sequential path wraps around the end of instruction memory.
  assign pc_plus4_raw  = pc_q + 32'd4;
  assign pc_plus4_wrap = pc_plus4_raw & ADDR_MASK;

  always_comb begin
    redirect = 1'b0;
    next_pc  = pc_plus4_wrap;
    if (JumpReg) begin
      redirect = 1'b1;
      next_pc  = RegTarget;
    end else if (Jump) begin
      redirect = 1'b1;
      next_pc  = {pc_plus4_raw[31:28], JumpIndex, 2'b00};
    end else if (Branch) begin
      redirect = 1'b1;
      next_pc  = pc_plus4_raw + (BranchOffset << 2);
    end
  end

  // A sequential wrap is always in range, so only redirects can fault.
  assign target_bad = redirect &&
                      ((next_pc[1:0] != 2'b00) || (next_pc >= IMEM_LIMIT));

  // Inputs are only looked at in RUN, so unknowns on the control inputs
  // cannot leak into the frozen HALT/FAULT state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    if ((state_q == ST_RUN) && !Stall) begin
      if (Instruct[31:26] == HALT_OPCODE) begin
        state_d  = ST_HALT;
        halted_d = 1'b1;
      end else if (target_bad) begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end else begin
        pc_d = next_pc;
        if (count_q != 32'hFFFF_FFFF) begin
          count_d = count_q + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      count_q  <= 32'd0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign ImemRdAddr = pc_q;
  assign PCPlus4    = pc_plus4_wrap;
  assign Halted     = halted_q;
  assign AddrFault  = fault_q;
  assign FetchCount = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed bench for pc_fetch_unit: sequential fetch with wrap, branch,
// redirect priority, stall masking HALT, HALT freeze, address faults and
// asynchronous reset. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

  localparam logic [31:0] HALT_WORD = {6'b111111, 26'd0};
  localparam logic [31:0] NOP_WORD  = 32'd0;

  logic        clk;
  logic        rst;
  logic        Stall;
  logic        Branch;
  logic [31:0] BranchOffset;
  logic        Jump;
  logic [25:0] JumpIndex;
  logic        JumpReg;
  logic [31:0] RegTarget;
  logic [31:0] Instruct;
  logic [31:0] ImemRdAddr;
  logic [31:0] PCPlus4;
  logic        Halted;
  logic        AddrFault;
  logic [31:0] FetchCount;

  int checkCount = 0;
  int errorCount = 0;

  pc_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .Stall        (Stall),
    .Branch       (Branch),
    .BranchOffset (BranchOffset),
    .Jump         (Jump),
    .JumpIndex    (JumpIndex),
    .JumpReg      (JumpReg),
    .RegTarget    (RegTarget),
    .Instruct     (Instruct),
    .ImemRdAddr   (ImemRdAddr),
    .PCPlus4      (PCPlus4),
    .Halted       (Halted),
    .AddrFault    (AddrFault),
    .FetchCount   (FetchCount)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then advance past the next rising edge so
  // outputs are sampled 1 ns after it.
  task automatic applyStimulus(input logic stallIn, input logic branchIn,
                               input logic [31:0] offsetIn, input logic jumpIn,
                               input logic [25:0] indexIn, input logic jregIn,
                               input logic [31:0] targetIn,
                               input logic [31:0] instrIn);
    Stall        = stallIn;
    Branch       = branchIn;
    BranchOffset = offsetIn;
    Jump         = jumpIn;
    JumpIndex    = indexIn;
    JumpReg      = jregIn;
    RegTarget    = targetIn;
    Instruct     = instrIn;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, NOP_WORD);
  endtask

  // Hold reset across two edges; the first edge after release fetches from
  // RESET_PC + 4.
  task automatic doReset();
    rst = 1'b1;
    idleCycle();
    idleCycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    Stall = 1'b0; Branch = 1'b0; BranchOffset = 32'd0; Jump = 1'b0;
    JumpIndex = 26'd0; JumpReg = 1'b0; RegTarget = 32'd0; Instruct = NOP_WORD;

    // Reset state
    doReset();
    checkOutput("rstPc", ImemRdAddr, 32'd0);
    checkOutput("rstCount", FetchCount, 32'd0);
    checkOutput("rstHalted", {31'd0, Halted}, 32'd0);
    checkOutput("rstFault", {31'd0, AddrFault}, 32'd0);
    checkOutput("rstPlus4", PCPlus4, 32'd4);

    // Free-running sequential fetch, wrapping 252 -> 0
    for (int i = 1; i <= 70; i++) begin
      idleCycle();
      checkOutput("seqPc", ImemRdAddr, 32'((i * 4) % 256));
      if (i == 63) checkOutput("wrapPlus4", PCPlus4, 32'd0);
      if (i == 64) checkOutput("wrapFault", {31'd0, AddrFault}, 32'd0);
    end
    checkOutput("seqCount", FetchCount, 32'd70);

    // Backward branch: 16 + 4 + (-3 << 2) = 8
    doReset();
    repeat (4) idleCycle();
    checkOutput("preBranchPc", ImemRdAddr, 32'd16);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, 26'd0, 1'b0, 32'd0, NOP_WORD);
    checkOutput("branchPc", ImemRdAddr, 32'd8);

    // JumpReg beats Branch in the same cycle
    applyStimulus(1'b0, 1'b1, 32'd5, 1'b0, 26'd0, 1'b1, 32'd40, NOP_WORD);
    checkOutput("jrPriorityPc", ImemRdAddr, 32'd40);

    // J-type jump: {0000, 25, 00} = 100
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 26'd25, 1'b0, 32'd0, NOP_WORD);
    checkOutput("jumpPc", ImemRdAddr, 32'd100);
    checkOutput("jumpCount", FetchCount, 32'd7);

    // Stall masks HALT, then HALT freezes fetch
    doReset();
    repeat (3) idleCycle();
    checkOutput("preHaltPc", ImemRdAddr, 32'd12);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, HALT_WORD);
      checkOutput("stallPc", ImemRdAddr, 32'd12);
      checkOutput("stallHalted", {31'd0, Halted}, 32'd0);
      checkOutput("stallCount", FetchCount, 32'd3);
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, HALT_WORD);
    checkOutput("haltFlag", {31'd0, Halted}, 32'd1);
    checkOutput("haltPc", ImemRdAddr, 32'd12);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, (i % 2) == 0, 26'd30, 1'b0, 32'd0, NOP_WORD);
      checkOutput("frozenPc", ImemRdAddr, 32'd12);
      checkOutput("frozenHalted", {31'd0, Halted}, 32'd1);
      checkOutput("frozenFault", {31'd0, AddrFault}, 32'd0);
      checkOutput("frozenCount", FetchCount, 32'd3);
    end

    // Misaligned register target faults and holds the PC
    doReset();
    idleCycle();
    checkOutput("preFaultPc", ImemRdAddr, 32'd4);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'd42, NOP_WORD);
    checkOutput("misalignFault", {31'd0, AddrFault}, 32'd1);
    checkOutput("misalignPc", ImemRdAddr, 32'd4);
    checkOutput("misalignHalted", {31'd0, Halted}, 32'd0);
    idleCycle();
    checkOutput("faultHeldPc", ImemRdAddr, 32'd4);
    checkOutput("faultHeldCount", FetchCount, 32'd1);

    // Target equal to memory size faults
    doReset();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'd256, NOP_WORD);
    checkOutput("rangeFault", {31'd0, AddrFault}, 32'd1);
    checkOutput("rangePc", ImemRdAddr, 32'd0);

    // Last word of memory is legal; sequential successor wraps to 0
    doReset();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'd252, NOP_WORD);
    checkOutput("edgePc", ImemRdAddr, 32'd252);
    checkOutput("edgeFault", {31'd0, AddrFault}, 32'd0);
    idleCycle();
    checkOutput("edgeWrapPc", ImemRdAddr, 32'd0);

    // Asynchronous reset while halted at 100
    doReset();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 26'd25, 1'b0, 32'd0, NOP_WORD);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, HALT_WORD);
    checkOutput("preAsyncPc", ImemRdAddr, 32'd100);
    checkOutput("preAsyncHalted", {31'd0, Halted}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncPc", ImemRdAddr, 32'd0);
    checkOutput("asyncHalted", {31'd0, Halted}, 32'd0);
    checkOutput("asyncCount", FetchCount, 32'd0);
    Instruct = NOP_WORD;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("resumePc", ImemRdAddr, 32'd4);
    checkOutput("resumeCount", FetchCount, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch-control stage of the single-cycle CPU; sits directly upstream of InstructMemory.
- Holds the PC and drives ImemRdAddr.
- Samples the returned Instruct to detect HALT, selects the next PC (sequential, branch, jump, jump-register) and flags illegal fetch targets.
- Keeps a retired-fetch counter for the test benches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 256, instruction memory size in bytes; power of two, multiple of 4.
- HALT_OPCODE, 6'b111111, Instruct[31:26] value that stops fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Stall  in  1  hold PC this cycle.
- Branch  in  1  taken conditional branch.
- BranchOffset  in  32  sign-extended word offset (imm16).
- Jump  in  1  J-type jump.
- JumpIndex  in  26  J-type target field.
- JumpReg  in  1  jump to register value.
- RegTarget  in  32  register jump target.
- Instruct  in  32  word returned by InstructMemory for ImemRdAddr.
- ImemRdAddr  out  32  current PC, byte address.
- PCPlus4  out  32  sequential successor, wrapped (see Behaviour).
- Halted  out  1  fetch stopped by HALT.
- AddrFault  out  1  fetch stopped by illegal redirect target.
- FetchCount  out  32  number of PC advances since reset.

Behaviour:
- Reset (async, rst=1), held while rst=1:
  - ImemRdAddr=RESET_PC, FetchCount=0, Halted=0, AddrFault=0, state=RUN.
  - Deasserting rst mid-operation resumes from RESET_PC on the next edge.
- States: RUN, HALT, FAULT. HALT and FAULT are terminal; only rst leaves them.
- PCPlus4 (combinational) = (ImemRdAddr+4) mod IMEM_BYTES. Sequential fetch wraps 252->0 for the default size. Sequential wrap is never a fault.
- Redirect target (combinational), priority JumpReg > Jump > Branch > sequential:
  - JumpReg: RegTarget.
  - Jump: {PCPlus4[31:28], JumpIndex, 2'b00}. Uses the unwrapped ImemRdAddr+4 upper bits.
  - Branch: (ImemRdAddr+4) + (BranchOffset<<2), 32-bit modular add; overflow bits discarded.
- Rising edge in RUN, evaluated in this order:
  1. Stall=1: PC, FetchCount and state hold. Stall also masks HALT detection and the fault check this edge.
  2. Instruct[31:26]==HALT_OPCODE: state->HALT, Halted=1, PC holds. Branch/Jump/JumpReg are ignored that edge.
  3. Redirect selected and target[1:0]!=0 or target>=IMEM_BYTES: state->FAULT, AddrFault=1, PC holds at the faulting instruction.
  4. Otherwise: ImemRdAddr<=next PC; FetchCount<=FetchCount+1, saturating at 32'hFFFF_FFFF.
- In HALT or FAULT:
  - All inputs except rst are ignored.
  - Outputs are frozen.
  - Halted and AddrFault are mutually exclusive.
- Latency: a redirect asserted in cycle n appears on ImemRdAddr after edge n; one edge, no delay slot.
- Outputs are registered except PCPlus4. ImemRdAddr never changes except on a clock edge or rst.
- X on control inputs while in HALT/FAULT must not propagate to outputs.

Test Plan:
- Reset then 70 free-running cycles, no redirects, Instruct opcode 0 -> ImemRdAddr 0,4,8,…,252,0,4; FetchCount=70; no fault at the wrap.
- PC=16, Branch=1, BranchOffset=32'hFFFF_FFFD -> next ImemRdAddr=8.
- PC=8, Branch=1 and JumpReg=1 with RegTarget=40 in the same cycle -> next ImemRdAddr=40; JumpReg wins.
- PC=12, Stall=1 for 3 cycles while Instruct opcode=6'b111111 -> PC stays 12, Halted=0, FetchCount unchanged. Stall drops -> Halted=1 after one edge; PC frozen at 12 through 5 further cycles with Jump toggling.
- PC=4, JumpReg=1, RegTarget=42 -> AddrFault=1, PC stays 4. Repeat from reset with RegTarget=256 -> AddrFault=1. Repeat with RegTarget=252 -> PC=252, no fault.
- Assert rst asynchronously mid-cycle while PC=100 and Halted=1 -> ImemRdAddr=0, Halted=0, FetchCount=0 before the next clock edge; fetch resumes at 4 after rst drops.
